// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int          FS_PC_W      = 16;
  localparam int          FS_INSTR_W   = 16;
  localparam logic [15:0] FS_RESET_PC  = 16'h0000;
  localparam logic [15:0] FS_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FS_REQ     = 2'd0,
    FS_HOLD    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, imem request handshake and the IF/ID
// register, with execute redirect and decode stall handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               PC_W      = FS_PC_W,
  parameter int               INSTR_W   = FS_INSTR_W,
  parameter logic [PC_W-1:0]  RESET_PC  = PC_W'(FS_RESET_PC),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FS_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_flush,
  input  logic [PC_W-1:0]    ex_pc_out,
  input  logic               id_stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_next
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [PC_W-1:0]    if_pc_next_q, if_pc_next_d;

  logic               slot_free;
  logic               consume;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    hold_pc_plus1;

  assign slot_free     = !if_valid_q || !id_stall;
  assign consume       = if_valid_q && !id_stall;
  assign pc_plus1      = pc_q + PC_ONE;
  assign hold_pc_plus1 = hold_pc_q + PC_ONE;

  // Next-state logic for the fetch FSM, PC and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_pc_next_d = if_pc_next_q;

    case (state_q)
      FS_REQ: begin
        if (ex_flush) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          if (imem_ready) begin
            pc_d = ex_pc_out;
          end else begin
            pend_pc_d = ex_pc_out;
            state_d   = FS_DISCARD;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus1;
          if (slot_free) begin
            if_valid_d   = 1'b1;
            if_instr_d   = imem_rdata;
            if_pc_d      = pc_q;
            if_pc_next_d = pc_plus1;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = FS_HOLD;
          end
        end else if (consume) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else begin
          if_valid_d = if_valid_q;
        end
      end
      FS_HOLD: begin
        if (ex_flush) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          pc_d       = ex_pc_out;
          state_d    = FS_REQ;
        end else if (!id_stall) begin
          if_valid_d   = 1'b1;
          if_instr_d   = hold_instr_q;
          if_pc_d      = hold_pc_q;
          if_pc_next_d = hold_pc_plus1;
          state_d      = FS_REQ;
        end else begin
          state_d = FS_HOLD;
        end
      end
      FS_DISCARD: begin
        // The killed request must complete at its original address before redirecting.
        if (imem_ready) begin
          pc_d    = ex_flush ? ex_pc_out : pend_pc_q;
          state_d = FS_REQ;
        end else if (ex_flush) begin
          pend_pc_d = ex_pc_out;
        end else begin
          state_d = FS_DISCARD;
        end
      end
      default: begin
        state_d    = FS_REQ;
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FS_REQ;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      if_pc_next_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pc_next_q <= if_pc_next_d;
    end
  end

  assign imem_req   = !rst && ((state_q == FS_REQ) || (state_q == FS_DISCARD));
  assign imem_addr  = pc_q;
  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign if_pc_next = if_pc_next_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cycle checks plus a scoreboard
// of the program-order instruction stream consumed by decode.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        ex_flush;
  logic [15:0] ex_pc_out;
  logic        id_stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_next;

  int          n_checks;
  int          n_pass;
  logic        mon_en;
  logic [15:0] sb_q[$];
  logic [15:0] exp_pc;
  logic [15:0] exp_next;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ex_flush   (ex_flush),
    .ex_pc_out  (ex_pc_out),
    .id_stall   (id_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_next (if_pc_next)
  );

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [15:0] first, input int count);
    logic [15:0] p;
    p = first;
    for (int i = 0; i < count; i++) begin
      sb_q.push_back(p);
      p = p + 16'd1;
    end
  endtask

  // Scoreboard: every instruction decode accepts (and execute does not kill) is popped and compared.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (if_valid && !id_stall && !ex_flush) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 16'(sb_q.size()), 16'd1);
        end else begin
          exp_pc   = sb_q.pop_front();
          exp_next = exp_pc + 16'd1;
          check_eq("sb_if_pc", if_pc, exp_pc);
          check_eq("sb_if_instr", if_instr, instr_of(exp_pc));
          check_eq("sb_if_pc_next", if_pc_next, exp_next);
        end
      end else if (!if_valid) begin
        check_eq("nop_when_invalid", if_instr, 16'h0000);
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    ex_flush   = 1'b0;
    ex_pc_out  = 16'h0000;
    id_stall   = 1'b0;
    imem_ready = 1'b1;

    // Reset for two edges.
    tick();
    check_eq("rst_req_low", 16'(imem_req), 16'd0);
    check_eq("rst_if_valid", 16'(if_valid), 16'd0);
    check_eq("rst_if_instr", if_instr, 16'h0000);
    check_eq("rst_if_pc", if_pc, 16'h0000);
    check_eq("rst_if_pc_next", if_pc_next, 16'h0000);
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    push_range(16'h0000, 7);

    // Streaming with ready tied high.
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("stream_addr", imem_addr, 16'(k));
      check_eq("stream_req", 16'(imem_req), 16'd1);
      if (k > 0) begin
        check_eq("stream_if_pc", if_pc, 16'(k - 1));
        check_eq("stream_if_pc_next", if_pc_next, 16'(k));
      end
      tick();
    end

    // Stall three cycles at if_pc=4.
    id_stall = 1'b1;
    #1; check_eq("stall_if_pc", if_pc, 16'h0004);
    tick();
    #1; check_eq("hold_req_low", 16'(imem_req), 16'd0);
    check_eq("hold_if_pc", if_pc, 16'h0004);
    tick();
    #1; check_eq("hold_req_low2", 16'(imem_req), 16'd0);
    tick();
    id_stall = 1'b0;
    #1; check_eq("release_if_pc", if_pc, 16'h0004);
    tick();
    #1; check_eq("after_release_pc5", if_pc, 16'h0005);
    check_eq("after_release_addr", imem_addr, 16'h0006);
    tick();
    #1; check_eq("after_release_pc6", if_pc, 16'h0006);
    tick();

    // Redirect with ready at if_pc=7.
    #1; check_eq("pre_flush_if_pc", if_pc, 16'h0007);
    ex_flush  = 1'b1;
    ex_pc_out = 16'h0040;
    sb_q.push_back(16'h0040);
    tick();
    ex_flush = 1'b0;
    #1; check_eq("flush_if_valid", 16'(if_valid), 16'd0);
    check_eq("flush_addr", imem_addr, 16'h0040);
    tick();
    #1; check_eq("flush_target_if_pc", if_pc, 16'h0040);
    tick();

    // Redirect to 9, then slow imem with a second flush while waiting.
    #1; check_eq("pre_flush2_if_pc", if_pc, 16'h0041);
    ex_flush  = 1'b1;
    ex_pc_out = 16'h0009;
    sb_q.push_back(16'h0080);
    tick();
    ex_pc_out  = 16'h0080;
    imem_ready = 1'b0;
    #1; check_eq("slow_addr_c1", imem_addr, 16'h0009);
    check_eq("slow_if_valid_c1", 16'(if_valid), 16'd0);
    tick();
    ex_flush = 1'b0;
    #1; check_eq("discard_addr_c2", imem_addr, 16'h0009);
    check_eq("discard_req_c2", 16'(imem_req), 16'd1);
    tick();
    #1; check_eq("discard_addr_c3", imem_addr, 16'h0009);
    tick();
    imem_ready = 1'b1;
    #1; check_eq("discard_addr_ready", imem_addr, 16'h0009);
    check_eq("discard_if_valid", 16'(if_valid), 16'd0);
    tick();
    #1; check_eq("discard_next_addr", imem_addr, 16'h0080);
    check_eq("discard_drop_valid", 16'(if_valid), 16'd0);
    tick();
    #1; check_eq("discard_target_if_pc", if_pc, 16'h0080);
    tick();

    // Flush while stalled in HOLD.
    id_stall = 1'b1;
    #1; check_eq("hold2_if_pc", if_pc, 16'h0081);
    check_eq("hold2_addr", imem_addr, 16'h0082);
    tick();
    ex_flush  = 1'b1;
    ex_pc_out = 16'h0010;
    sb_q.push_back(16'h0010);
    #1; check_eq("hold2_req_low", 16'(imem_req), 16'd0);
    check_eq("hold2_valid", 16'(if_valid), 16'd1);
    tick();
    id_stall = 1'b0;
    ex_flush = 1'b0;
    #1; check_eq("hold_flush_valid", 16'(if_valid), 16'd0);
    check_eq("hold_flush_addr", imem_addr, 16'h0010);
    check_eq("hold_flush_req", 16'(imem_req), 16'd1);
    tick();
    #1; check_eq("hold_flush_target", if_pc, 16'h0010);
    tick();

    // Wrap through 0xFFFF.
    ex_flush  = 1'b1;
    ex_pc_out = 16'hFFFE;
    push_range(16'hFFFE, 4);
    tick();
    ex_flush = 1'b0;
    #1; check_eq("wrap_addr_fffe", imem_addr, 16'hFFFE);
    tick();
    #1; check_eq("wrap_if_pc_fffe", if_pc, 16'hFFFE);
    check_eq("wrap_addr_ffff", imem_addr, 16'hFFFF);
    tick();
    #1; check_eq("wrap_if_pc_ffff", if_pc, 16'hFFFF);
    check_eq("wrap_if_pc_next", if_pc_next, 16'h0000);
    check_eq("wrap_addr_0000", imem_addr, 16'h0000);
    tick();
    #1; check_eq("wrap_if_pc_0000", if_pc, 16'h0000);
    tick();

    // Reset in the middle of an outstanding request.
    imem_ready = 1'b0;
    #1; check_eq("pre_rst_addr", imem_addr, 16'h0002);
    tick();
    rst = 1'b1;
    #1; check_eq("midrst_req_low", 16'(imem_req), 16'd0);
    tick();
    #1; check_eq("midrst_req_low2", 16'(imem_req), 16'd0);
    check_eq("midrst_if_valid", 16'(if_valid), 16'd0);
    check_eq("midrst_if_pc_next", if_pc_next, 16'h0000);
    tick();
    rst = 1'b0;
    push_range(16'h0000, 2);
    #1; check_eq("postrst_req", 16'(imem_req), 16'd1);
    check_eq("postrst_addr", imem_addr, 16'h0000);
    check_eq("postrst_if_valid", 16'(if_valid), 16'd0);
    tick();
    imem_ready = 1'b1;
    #1; check_eq("postrst_addr_ready", imem_addr, 16'h0000);
    tick();
    #1; check_eq("postrst_if_pc", if_pc, 16'h0000);
    check_eq("postrst_if_instr", if_instr, instr_of(16'h0000));
    check_eq("postrst_next_addr", imem_addr, 16'h0001);
    tick();
    #1; check_eq("postrst_if_pc1", if_pc, 16'h0001);
    tick();
    id_stall = 1'b1;
    tick();
    tick();
    check_eq("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
